// File: rtl/ir_tx_nec.sv
// rtl/ir_tx_nec.sv - NEC infrared frame serialiser, idle-high active-low line output
module ir_tx_nec #(
  parameter int P_TICK_CYC = 50,
  parameter int P_LEAD_LO  = 9000,
  parameter int P_LEAD_HI  = 4500,
  parameter int P_RPT_HI   = 2250,
  parameter int P_BIT_LO   = 560,
  parameter int P_ZERO_HI  = 565,
  parameter int P_ONE_HI   = 1690,
  parameter int P_STOP_LO  = 560
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_rpt,
  input  logic [31:0] i_data,
  output logic        o_ir_txb,
  output logic        o_busy,
  output logic        o_done
);

  localparam int TW = (P_TICK_CYC > 1) ? $clog2(P_TICK_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD_LO, S_LEAD_HI, S_BIT_LO, S_BIT_HI, S_STOP_LO
  } state_t;

  state_t      state, state_nxt;
  logic [TW-1:0] tick_cnt;
  logic [13:0] ph_cnt;
  logic [13:0] ph_len;
  logic [31:0] data_q;
  logic        rpt_q;
  logic [4:0]  bit_idx;
  logic        tick_end;
  logic        phase_end;
  logic        accept;

  // The done cycle is already IDLE, but a start there is deliberately refused.
  assign accept    = (state == S_IDLE) && i_start && !o_done;
  assign tick_end  = (tick_cnt == TW'(P_TICK_CYC - 1));
  assign phase_end = tick_end && (ph_cnt == ph_len - 14'd1);

  always_comb begin
    ph_len = 14'd1;
    case (state)
      S_LEAD_LO: ph_len = 14'(P_LEAD_LO);
      S_LEAD_HI: ph_len = rpt_q ? 14'(P_RPT_HI) : 14'(P_LEAD_HI);
      S_BIT_LO:  ph_len = 14'(P_BIT_LO);
      S_BIT_HI:  ph_len = data_q[bit_idx] ? 14'(P_ONE_HI) : 14'(P_ZERO_HI);
      S_STOP_LO: ph_len = 14'(P_STOP_LO);
      default:   ph_len = 14'd1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (accept)    state_nxt = S_LEAD_LO;
      S_LEAD_LO: if (phase_end) state_nxt = S_LEAD_HI;
      S_LEAD_HI: if (phase_end) state_nxt = rpt_q ? S_STOP_LO : S_BIT_LO;
      S_BIT_LO:  if (phase_end) state_nxt = S_BIT_HI;
      S_BIT_HI:  if (phase_end) state_nxt = (bit_idx == 5'd0) ? S_STOP_LO : S_BIT_LO;
      S_STOP_LO: if (phase_end) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ir_txb = 1'b1;
    o_busy   = (state != S_IDLE);
    if (state == S_LEAD_LO || state == S_BIT_LO || state == S_STOP_LO)
      o_ir_txb = 1'b0;
  end

  // Counters restart on every boundary so each phase is exactly N ticks long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
      ph_cnt   <= '0;
    end else if (state == S_IDLE || phase_end) begin
      tick_cnt <= '0;
      ph_cnt   <= '0;
    end else if (tick_end) begin
      tick_cnt <= '0;
      ph_cnt   <= ph_cnt + 14'd1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      rpt_q   <= 1'b0;
      bit_idx <= '0;
    end else if (accept) begin
      data_q  <= i_data;
      rpt_q   <= i_rpt;
      bit_idx <= 5'd31;
    end else if (state == S_BIT_HI && phase_end) begin
      bit_idx <= bit_idx - 5'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) o_done <= 1'b0;
    else     o_done <= (state == S_STOP_LO) && phase_end;
  end

endmodule

// File: tb/tb_ir_tx_nec.sv
// tb/tb_ir_tx_nec.sv - scoreboard bench for ir_tx_nec with a segment-level frame model
module tb_ir_tx_nec;

  localparam int T  = 3;
  localparam int LL = 12;
  localparam int LH = 6;
  localparam int RH = 4;
  localparam int BL = 2;
  localparam int ZH = 2;
  localparam int OH = 5;
  localparam int SL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic        i_rpt;
  logic [31:0] i_data;
  logic        o_ir_txb;
  logic        o_busy;
  logic        o_done;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  ir_tx_nec #(
    .P_TICK_CYC(T), .P_LEAD_LO(LL), .P_LEAD_HI(LH), .P_RPT_HI(RH),
    .P_BIT_LO(BL), .P_ZERO_HI(ZH), .P_ONE_HI(OH), .P_STOP_LO(SL)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_rpt(i_rpt), .i_data(i_data),
    .o_ir_txb(o_ir_txb), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  // Reference: a frame is an alternating low/high list of durations in clk cycles, -1 ends it.
  task automatic push_frame(input logic [31:0] d, input logic r);
    exp_q.push_back(T * LL);
    if (r) begin
      exp_q.push_back(T * RH);
    end else begin
      exp_q.push_back(T * LH);
      for (int i = 31; i >= 0; i--) begin
        exp_q.push_back(T * BL);
        exp_q.push_back(T * (d[i] ? OH : ZH));
      end
    end
    exp_q.push_back(T * SL);
    exp_q.push_back(-1);
  endtask

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic r);
    @(posedge clk); #1;
    i_start = 1'b1; i_data = d; i_rpt = r;
    push_frame(d, r);
    @(posedge clk); #1;
    i_start = 1'b0; i_data = $urandom; i_rpt = $urandom_range(0, 1);
  endtask

  task automatic wait_done();
    bit got = 0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(negedge clk);
      if (o_done) got = 1;
    end
    check("done_timeout", int'(got), 1);
  endtask

  // Monitor: records line segments while busy and scores them when busy drops.
  initial begin
    int seg_q[$];
    int cur_len;
    logic cur_lvl;
    logic prev_busy;
    logic exp_done;
    int k;
    int e;
    int want_lvl;
    prev_busy = 1'b0;
    cur_len = 0;
    cur_lvl = 1'b1;
    forever begin
      @(negedge clk);
      if (rst) begin
        seg_q.delete();
        prev_busy = 1'b0;
        cur_len = 0;
      end else begin
        exp_done = prev_busy && !o_busy;
        if (o_done || exp_done) check("done_pulse", int'(o_done), int'(exp_done));
        if (o_busy) begin
          if (!prev_busy || o_ir_txb !== cur_lvl) begin
            if (prev_busy) seg_q.push_back(cur_len * 2 + int'(cur_lvl));
            cur_lvl = o_ir_txb;
            cur_len = 1;
          end else begin
            cur_len++;
          end
        end else begin
          check("idle_line", int'(o_ir_txb), 1);
          if (prev_busy) begin
            seg_q.push_back(cur_len * 2 + int'(cur_lvl));
            check("frame_expected", int'(exp_q.size() > 0), 1);
            k = 0;
            want_lvl = 0;
            while (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              if (e < 0) break;
              checks++;
              if (k >= seg_q.size()) begin
                errors++;
                $display("FAIL seg%0d: missing, want len=%0d lvl=%0d", k, e, want_lvl);
              end else if (seg_q[k] != e * 2 + want_lvl) begin
                errors++;
                $display("FAIL seg%0d: got len=%0d lvl=%0d, want len=%0d lvl=%0d",
                         k, seg_q[k] / 2, seg_q[k] % 2, e, want_lvl);
              end
              k++;
              want_lvl ^= 1;
            end
            check("seg_count", seg_q.size(), k);
            seg_q.delete();
          end
        end
        prev_busy = o_busy;
      end
    end
  end

  initial begin
    logic [31:0] a;
    rst = 1'b1; i_start = 1'b0; i_rpt = 1'b0; i_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txb", int'(o_ir_txb), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    send(32'h530F0001, 1'b0); wait_done();
    send(32'h00000000, 1'b0); wait_done();
    send(32'hFFFFFFFF, 1'b0); wait_done();
    send(32'h12345678, 1'b1); wait_done();

    for (int i = 0; i < 8; i++) begin
      send($urandom, ($urandom_range(0, 3) == 0));
      wait_done();
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    a = $urandom;
    send(a, 1'b0);
    repeat (20) @(posedge clk);
    #1 i_start = 1'b1; i_data = ~a; i_rpt = 1'b1;
    @(posedge clk); #1 i_start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    check("no_second_frame", int'(o_busy), 0);

    a = $urandom;
    send(a, 1'b0);
    wait_done();
    i_start = 1'b1; i_data = 32'hA5A5F00F; i_rpt = 1'b0;
    push_frame(32'hA5A5F00F, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("start_on_done_ignored", int'(o_busy), 0);
    @(posedge clk); #1 i_start = 1'b0;
    @(negedge clk);
    check("start_after_done_busy", int'(o_busy), 1);
    wait_done();

    send(32'hC3C3C3C3, 1'b0);
    repeat (56) @(posedge clk);
    #2;
    check("pre_rst_burst", int'(o_ir_txb), 0);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_txb", int'(o_ir_txb), 1);
    check("async_rst_busy", int'(o_busy), 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("post_rst_idle", int'(o_busy), 0);
    send(32'h0F0F1234, 1'b0); wait_done();

    repeat (5) @(negedge clk);
    check("all_frames_seen", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
